inst_cache: RTL and testbench
=============================

// Module: inst_cache
// PURPOSE
//   Direct-mapped, read-only instruction cache between the CPU fetch port
//   (ce/addr/data) and a slow multi-cycle instruction ROM. Hits return the
//   instruction combinationally in the fetch cycle. Misses raise a stall
//   request to ctrl and refill one line by burst from ROM.
// PARAMETERS
//   LINES     16  number of cache lines, power of 2 (>=2)
//   LINE_WORDS 4  32-bit words per line, power of 2 (>=2)
//   ADDR_W    32  byte-address width
// PORTS
//   clk           in   1       system clock
//   rst           in   1       synchronous, active-high reset
//   ce_i          in   1       fetch enable from pc
//   addr_i        in   ADDR_W  fetch byte address; bits [1:0] always 0
//   data_o        out  32      instruction for addr_i; 0 when ce_i=0 or on a miss
//   stallreq_o    out  1       to ctrl; 1 while ce_i=1 and lookup misses
//   flush_i       in   1       invalidate all lines (fence/self-modifying code)
//   mem_req_o     out  1       ROM burst request
//   mem_addr_o    out  ADDR_W  line-aligned burst base address
//   mem_rdata_i   in   32      ROM read data
//   mem_rvalid_i  in   1       one beat of mem_rdata_i is valid this cycle
// BEHAVIOUR
//   - Clock and reset: clk, with rst synchronous and active-high. All
//     state is updated on the rising edge of clk.
//   - Address split: off = addr[$clog2(LINE_WORDS)+1:2];
//     idx = next $clog2(LINES) bits; tag = remaining upper bits.
//   - Storage: valid[LINES], tag[LINES], data[LINES][LINE_WORDS], all in flops.
//   - hit = ce_i & valid[idx] & (tag[idx]==addr tag). All combinational:
//     data_o = hit ? data[idx][off] : 0; stallreq_o = ce_i & ~hit.
//   - FSM states:
//     - IDLE: no refill in progress.
//       - If ce_i & ~hit, go to REFILL next cycle.
//       - On that transition, latch base = {addr tag, idx, zeros}.
//       - Clear the beat counter.
//     - REFILL: mem_req_o=1 and mem_addr_o=base, both held stable.
//       - Each mem_rvalid_i beat writes data[base idx][cnt] and increments cnt.
//       - Beats arrive in word order. Gaps between beats are legal.
//       - When the beat with cnt==LINE_WORDS-1 arrives: set valid and tag
//         for the line, drop mem_req_o next cycle, and go to IDLE.
//       - The next lookup of the same address hits, so stallreq_o falls one
//         cycle after the last beat.
//   - mem_req_o=0 and mem_addr_o=0 in IDLE.
//   - A single refill is outstanding at a time. addr_i changes during REFILL
//     (should not occur while stalled) never change base.
//   - mem_rvalid_i received in IDLE is ignored.
//   - flush_i:
//     - In IDLE: clears all valid bits next cycle.
//     - In REFILL: is recorded. When the refill completes, the refilled line
//       is not marked valid and all valid bits are cleared.
//     - flush_i in the same cycle as a hit lookup still returns the hit data
//       that cycle.
//   - Reset:
//     - All valid bits are cleared. State=IDLE, cnt=0, pending flush=0,
//       mem_req_o=0, mem_addr_o=0.
//     - Tag and data arrays need no reset.
//     - Reset during REFILL aborts the burst immediately: mem_req_o=0 the
//       following cycle. The ROM must tolerate a dropped request.
//   - Outputs during reset: data_o=0 and stallreq_o=0, because pc holds ce=0
//     under reset.
// TESTING
//   1. Cold miss: after rst, ce=1, addr=0x0000_0000.
//      -> stallreq_o=1.
//      -> Next cycle mem_req_o=1, mem_addr_o=0x0.
//      -> Feed 0x11,0x22,0x33,0x44 on 4 beats. mem_req_o falls, stallreq_o=0,
//         data_o=0x11.
//   2. Line hits: after test 1, addr 0x4, 0x8, 0xC.
//      -> data_o=0x22,0x33,0x44 with no stall and mem_req_o stays 0.
//   3. Conflict: addr=0x100 (same idx 0, different tag, defaults).
//      -> Miss and refill of base 0x100.
//      -> Revisiting 0x0 misses again.
//   4. Beat gaps: mem_rvalid_i asserted with 3 idle cycles between beats.
//      -> Data is stored in order. stallreq_o stays 1 until the cycle after
//         the 4th beat.
//   5. Flush: flush_i pulse in IDLE, then addr 0x4.
//      -> Miss.
//      -> flush_i during a refill: the next fetch of the same line misses again.
//   6. Reset mid-refill: rst after 2 beats.
//      -> mem_req_o=0 the next cycle.
//      -> After rst, a fetch of 0x0 misses and a full 4-beat refill is issued.

Source files
------------

// File: rtl/inst_cache_if.sv
// Fetch-side and ROM-side signals of the instruction cache, bundled so the
// cache, the CPU fetch stage and the ROM can be wired with one connection.
//
// ROM handshake: mem_req_o is a level request. While it is high, mem_addr_o
// holds a stable line-aligned base address. The ROM answers with beats in
// ascending word order, one per cycle in which mem_rvalid_i=1. Idle cycles
// between beats are allowed, and the cache never applies back-pressure.
// The request may drop before the burst ends (reset), and the ROM must then
// abandon the burst.
interface inst_cache_if #(
   parameter int ADDR_W = 32
);
   logic              ce_i;
   logic [ADDR_W-1:0] addr_i;
   logic [31:0]       data_o;
   logic              stallreq_o;
   logic              flush_i;
   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_rdata_i;
   logic              mem_rvalid_i;

   // Cache side
   modport slave (
      input  ce_i, addr_i, flush_i, mem_rdata_i, mem_rvalid_i,
      output data_o, stallreq_o, mem_req_o, mem_addr_o
   );

   // Fetch stage / ROM / testbench side
   modport master (
      output ce_i, addr_i, flush_i, mem_rdata_i, mem_rvalid_i,
      input  data_o, stallreq_o, mem_req_o, mem_addr_o
   );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache. Hits are answered
// combinationally in the fetch cycle. A miss stalls the CPU and refills one
// line from the ROM by burst. dbg_state exposes the refill FSM state
// (0 = IDLE, 1 = REFILL).
module inst_cache #(
   parameter int LINES      = 16,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   inst_cache_if.slave  bus,
   output logic         dbg_state
);

   localparam int OFF_W   = $clog2(LINE_WORDS);
   localparam int IDX_W   = $clog2(LINES);
   localparam int LSB_IDX = OFF_W + 2;
   localparam int LSB_TAG = LSB_IDX + IDX_W;
   localparam int TAG_W   = ADDR_W - LSB_TAG;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_REFILL = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [31:0]       data_q [LINES][LINE_WORDS];
   logic [ADDR_W-1:0] base_q;
   logic [OFF_W-1:0]  cnt_q;
   logic              flush_pend_q;

   logic [OFF_W-1:0]  req_off;
   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  base_idx;
   logic [TAG_W-1:0]  base_tag;
   logic              hit;
   logic              start_refill;
   logic              beat_we;
   logic              line_done;
   logic [1:0]        addr_unused;

   // Fetch address split. The byte-offset bits are always zero.
   assign req_off     = bus.addr_i[2 +: OFF_W];
   assign req_idx     = bus.addr_i[LSB_IDX +: IDX_W];
   assign req_tag     = bus.addr_i[LSB_TAG +: TAG_W];
   assign addr_unused = bus.addr_i[1:0];

   assign base_idx = base_q[LSB_IDX +: IDX_W];
   assign base_tag = base_q[LSB_TAG +: TAG_W];

   assign hit            = bus.ce_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
   assign bus.data_o     = hit ? data_q[req_idx][req_off] : 32'h0;
   assign bus.stallreq_o = bus.ce_i & ~hit;

   // The request is driven straight from the state, so it drops in the
   // cycle after the final beat and immediately after reset.
   assign bus.mem_req_o  = (state_q == S_REFILL);
   assign bus.mem_addr_o = (state_q == S_REFILL) ? base_q : '0;
   assign dbg_state      = state_q;

   // Refill FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state and per-cycle refill strobes
   always_comb begin
      state_d      = state_q;
      start_refill = 1'b0;
      beat_we      = 1'b0;
      line_done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.ce_i && !hit) begin
               state_d      = S_REFILL;
               start_refill = 1'b1;
            end
         end
         S_REFILL: begin
            if (bus.mem_rvalid_i) begin
               beat_we = 1'b1;
               // LINE_WORDS is a power of two, so the last beat is all-ones.
               if (&cnt_q) begin
                  line_done = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state: valid bits, burst base, beat counter, deferred flush
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= '0;
         base_q       <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         if (start_refill) begin
            base_q <= {req_tag, req_idx, {(OFF_W+2){1'b0}}};
            cnt_q  <= '0;
         end
         if (beat_we) cnt_q <= cnt_q + 1'b1;

         if (state_q == S_IDLE) begin
            flush_pend_q <= 1'b0;
            if (bus.flush_i) valid_q <= '0;
         end else begin
            // A flush seen mid-burst is held until the line completes, so the
            // line being filled is never marked valid.
            if (bus.flush_i) flush_pend_q <= 1'b1;
            if (line_done) begin
               flush_pend_q <= 1'b0;
               if (flush_pend_q || bus.flush_i) valid_q <= '0;
               else                             valid_q[base_idx] <= 1'b1;
            end
         end
      end
   end

   // Tag array written once per completed line (no reset needed)
   always_ff @(posedge clk) begin
      if (line_done) tag_q[base_idx] <= base_tag;
   end

   // Data array written one word per ROM beat (no reset needed)
   always_ff @(posedge clk) begin
      if (beat_we) data_q[base_idx][cnt_q] <= bus.mem_rdata_i;
   end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache. It models the ROM as a word array, pushes
// the expected instruction for every fetch into a queue, and pops and
// compares it once the cache stops stalling.
module tb_inst_cache;

   logic clk;
   logic rst;
   logic dbg_state;

   inst_cache_if #(.ADDR_W(32)) bus ();

   inst_cache #(
      .LINES(16),
      .LINE_WORDS(4),
      .ADDR_W(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .dbg_state(dbg_state)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   logic [31:0] rom [0:255];
   logic [31:0] exp_q [$];
   int          pass_cnt  = 0;
   int          total_cnt = 0;

   // Move to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ROM side: serve one 4-beat burst for base, with gap idle cycles between
   // beats and flush_i raised alongside beat fl_beat (-1 for none).
   task automatic refill_line(input logic [31:0] base, input int gap, input int fl_beat);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            for (int g = 0; g < gap; g++) begin
               tick();
               bus.mem_rvalid_i = 1'b0;
               bus.flush_i      = 1'b0;
               #1;
               check("gap_stall", bus.stallreq_o, 1);
               check("gap_req", bus.mem_req_o, 1);
            end
         end
         tick();
         bus.mem_rvalid_i = 1'b1;
         bus.mem_rdata_i  = rom[base[9:2] + 8'(k)];
         bus.flush_i      = (k == fl_beat);
         #1;
         check("refill_req", bus.mem_req_o, 1);
         check("refill_addr", bus.mem_addr_o, base);
         check("refill_stall", bus.stallreq_o, 1);
      end
      tick();
      bus.mem_rvalid_i = 1'b0;
      bus.flush_i      = 1'b0;
      #1;
   endtask

   // CPU side: fetch address a, expect a hit or miss, and check the returned word
   task automatic fetch(input logic [31:0] a, input logic miss, input int gap, input int fl_beat);
      logic [31:0] base;
      int          n;
      base = a & ~32'hF;
      tick();
      bus.ce_i         = 1'b1;
      bus.addr_i       = a;
      bus.flush_i      = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      exp_q.push_back(rom[a[9:2]]);
      #1;
      check("lookup_stall", bus.stallreq_o, miss);
      if (miss) begin
         check("miss_data_zero", bus.data_o, 0);
         refill_line(base, gap, fl_beat);
         if (fl_beat >= 0) begin
            check("stall_after_flushed_refill", bus.stallreq_o, 1);
            refill_line(base, gap, -1);
         end
         check("stall_after_last_beat", bus.stallreq_o, 0);
         check("req_dropped", bus.mem_req_o, 0);
      end else begin
         check("no_req_on_hit", bus.mem_req_o, 0);
      end
      n = 0;
      while (bus.stallreq_o && n < 8) begin
         tick();
         #1;
         n++;
      end
      check("fetch_data", bus.data_o, exp_q.pop_front());
   endtask

   // Directed sequence
   initial begin
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;

      rst              = 1'b1;
      bus.ce_i         = 1'b0;
      bus.addr_i       = '0;
      bus.flush_i      = 1'b0;
      bus.mem_rdata_i  = '0;
      bus.mem_rvalid_i = 1'b0;
      repeat (3) tick();
      #1;
      check("reset_req", bus.mem_req_o, 0);
      check("reset_addr", bus.mem_addr_o, 0);
      check("reset_stall", bus.stallreq_o, 0);
      check("reset_data", bus.data_o, 0);
      check("reset_state", dbg_state, 0);
      rst = 1'b0;

      // Cold miss, then hits within the line
      fetch(32'h0, 1, 0, -1);
      fetch(32'h4, 0, 0, -1);
      fetch(32'h8, 0, 0, -1);
      fetch(32'hC, 0, 0, -1);

      // Conflict on index 0
      fetch(32'h100, 1, 0, -1);
      fetch(32'h0,   1, 0, -1);
      fetch(32'h104, 1, 0, -1);

      // Beat gaps, then check word order
      fetch(32'h20, 1, 3, -1);
      fetch(32'h24, 0, 0, -1);
      fetch(32'h28, 0, 0, -1);
      fetch(32'h2C, 0, 0, -1);

      // Flush in IDLE
      tick();
      bus.ce_i    = 1'b0;
      bus.flush_i = 1'b1;
      #1;
      check("idle_ce0_data", bus.data_o, 0);
      check("idle_ce0_stall", bus.stallreq_o, 0);
      tick();
      bus.flush_i = 1'b0;
      fetch(32'h4,  1, 0, -1);
      fetch(32'h2C, 1, 0, -1);

      // Flush during a refill: the refilled line must not become valid
      fetch(32'h40, 1, 1, 1);

      // Flush in the same cycle as a hit still returns the data
      tick();
      bus.ce_i    = 1'b1;
      bus.addr_i  = 32'h44;
      bus.flush_i = 1'b1;
      exp_q.push_back(rom[8'h11]);
      #1;
      check("flush_hit_stall", bus.stallreq_o, 0);
      check("flush_hit_data", bus.data_o, exp_q.pop_front());
      tick();
      bus.flush_i = 1'b0;
      #1;
      check("after_flush_stall", bus.stallreq_o, 1);
      fetch(32'h44, 1, 0, -1);

      // Reset in the middle of a refill
      fetch(32'h0, 1, 0, -1);
      tick();
      bus.flush_i = 1'b1;
      bus.ce_i    = 1'b0;
      tick();
      bus.flush_i = 1'b0;
      bus.ce_i    = 1'b1;
      bus.addr_i  = 32'h0;
      #1;
      check("pre_reset_stall", bus.stallreq_o, 1);
      tick();
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = rom[0];
      #1;
      check("pre_reset_req", bus.mem_req_o, 1);
      tick();
      bus.mem_rdata_i = rom[1];
      tick();
      bus.mem_rvalid_i = 1'b0;
      bus.ce_i         = 1'b0;
      rst              = 1'b1;
      tick();
      #1;
      check("abort_req", bus.mem_req_o, 0);
      check("abort_addr", bus.mem_addr_o, 0);
      check("abort_state", dbg_state, 0);
      check("abort_stall", bus.stallreq_o, 0);
      check("abort_data", bus.data_o, 0);
      rst = 1'b0;
      fetch(32'h0, 1, 0, -1);
      fetch(32'hC, 0, 0, -1);

      tick();
      bus.ce_i = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
